calc_cmd_sequencer: RTL
=======================

CALC_CMD_SEQUENCER -- requirements
Module: calc_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth; power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream command present.
REQ-005 in_ready  output  1  FIFO can accept a command; equals !full.
REQ-006 in_x, in_y  input  8 each  signed operands.
REQ-007 in_sel  input  2  opcode: 0 ADD, 1 SUB, 2 MUL, 3 EXP (1<<y).
REQ-008 calc_x, calc_y  output  8 each  operands driven to the downstream combinational calculator.
REQ-009 calc_sel  output  2  opcode driven to the calculator.
REQ-010 calc_out  input  8  signed calculator result, combinational from calc_x/calc_y/calc_sel.
REQ-011 res_valid  output  1  result register holds an undelivered result.
REQ-012 res_ready  input  1  downstream accepts the result.
REQ-013 res_data  output  8  registered result.
REQ-014 fifo_count  output  $clog2(DEPTH)+1  commands currently queued.

Function
REQ-015 Push SHALL occur when in_valid && in_ready; {in_sel,in_x,in_y} SHALL be written at the write pointer.
REQ-016 When full, in_ready SHALL be 0 even if a pop occurs in the same cycle.
REQ-017 Simultaneous push and pop when not full SHALL leave fifo_count unchanged and preserve order.
REQ-018 Pointers SHALL wrap modulo DEPTH, with one extra bit distinguishing full from empty.
REQ-019 The FSM SHALL have three states: IDLE, EXEC, DONE.
REQ-020 IDLE: if FIFO is non-empty, pop the head into the operand register and go to EXEC; otherwise stay.
REQ-021 EXEC: calc_* SHALL be driven from the operand register; on the edge, capture calc_out into res_data, set res_valid=1, and go to DONE.
REQ-022 DONE: hold res_data and res_valid=1 until res_ready=1. On that edge, clear res_valid; if FIFO is non-empty, pop and go to EXEC, else go to IDLE.
REQ-023 Latency: command pushed into an empty FIFO while in IDLE at edge N SHALL produce res_valid=1 after edge N+2.
REQ-024 Throughput with res_ready held 1: one result every 2 cycles.
REQ-025 calc_x/calc_y/calc_sel SHALL be stable (operand register) throughout EXEC and DONE; no combinational path from in_* to calc_*.
REQ-026 res_data SHALL change only on entry to DONE.
REQ-027 Commands SHALL complete in FIFO order; none dropped or duplicated.

Reset
REQ-028 While rst=1 at an edge: FSM to IDLE, pointers and fifo_count to 0, res_valid=0, res_data=0, operand register (calc_x, calc_y, calc_sel) to 0.
REQ-029 Reset mid-operation SHALL discard queued commands and any pending result; in_ready=1 in the first cycle after reset deasserts.
REQ-030 FIFO storage contents need not be reset.

Configuration
REQ-031 Macro CALC_SEQ_STATUS_EN defined: add outputs res_ovf (1) and res_zero (1), both registered with res_data and reset to 0.
REQ-032 res_zero SHALL equal (captured calc_out == 0).
REQ-033 res_ovf SHALL be set for signed overflow of ADD/SUB on the operand register, or for EXP with y outside 0..6; it SHALL be 0 for MUL.
REQ-034 Macro undefined: res_ovf and res_zero ports and logic SHALL be absent; all other behaviour is identical.

Verification
REQ-035 Reset, then push {ADD,5,3} with res_ready=1 -> res_valid=1 two edges after push, res_data=8, fifo_count back to 0.
REQ-036 res_ready=0; push DEPTH+1 commands back-to-back -> in_ready=0 after DEPTH+1 accepted pushes (one in operand register, DEPTH queued); no command lost once drained.
REQ-037 Queue {SUB,10,3},{MUL,-4,6},{EXP,0,5}; res_ready=1 -> results 7, -24, 32 in order, one every 2 cycles.
REQ-038 Assert rst while in DONE with 2 commands queued -> res_valid=0, fifo_count=0 next cycle; no stale result appears afterwards.
REQ-039 With CALC_SEQ_STATUS_EN: {ADD,100,100} -> res_data=-56, res_ovf=1; {SUB,3,3} -> res_data=0, res_zero=1, res_ovf=0.

Source files
------------

// File: rtl/calc_cmd_sequencer.sv
// Command FIFO feeding an external combinational calculator through an IDLE/EXEC/DONE sequencer.
// Optional status outputs res_ovf/res_zero are enabled with the CALC_SEQ_STATUS_EN macro.
module calc_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_x,
    input  logic [7:0]               in_y,
    input  logic [1:0]               in_sel,
    output logic [7:0]               calc_x,
    output logic [7:0]               calc_y,
    output logic [1:0]               calc_sel,
    input  logic [7:0]               calc_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [7:0]               res_data,
`ifdef CALC_SEQ_STATUS_EN
    output logic                     res_ovf,
    output logic                     res_zero,
`endif
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r;
    logic [17:0]    mem_r [DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [PW-1:0]  count_r;
    logic [17:0]    head_s;
    logic           full_s;
    logic           empty_s;
    logic           push_s;
    logic           pop_s;

`ifdef CALC_SEQ_STATUS_EN
    // Signed overflow of the operation itself, evaluated on the operand register.
    function automatic logic calc_ovf(input logic [1:0] sel, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        case (sel)
            2'd0: begin
                r = x + y;
                return (x[7] == y[7]) && (r[7] != x[7]);
            end
            2'd1: begin
                r = x - y;
                return (x[7] != y[7]) && (r[7] != x[7]);
            end
            2'd3:    return ($signed(y) < 8'sd0) || ($signed(y) > 8'sd6);
            default: return 1'b0;
        endcase
    endfunction
`endif

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign in_ready   = !full_s;
    assign head_s     = mem_r[rd_ptr_r[AW-1:0]];
    assign fifo_count = count_r;

    // Handshake decode: push when accepted, pop when the sequencer can take a new command.
    always_comb begin
        push_s = in_valid && !full_s;
        pop_s  = 1'b0;
        if (!empty_s) begin
            case (state_r)
                IDLE:    pop_s = 1'b1;
                DONE:    pop_s = res_ready;
                default: pop_s = 1'b0;
            endcase
        end else begin
            pop_s = 1'b0;
        end
    end

    // FIFO storage write; contents are not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {in_sel, in_x, in_y};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + PW'(1);
                2'b01:   count_r <= count_r - PW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sequencer: operand register, result register and state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            calc_x    <= 8'd0;
            calc_y    <= 8'd0;
            calc_sel  <= 2'd0;
            res_valid <= 1'b0;
            res_data  <= 8'd0;
`ifdef CALC_SEQ_STATUS_EN
            res_ovf   <= 1'b0;
            res_zero  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        {calc_sel, calc_x, calc_y} <= head_s;
                        state_r <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    res_data  <= calc_out;
                    res_valid <= 1'b1;
`ifdef CALC_SEQ_STATUS_EN
                    res_ovf   <= calc_ovf(calc_sel, calc_x, calc_y);
                    res_zero  <= (calc_out == 8'd0);
`endif
                    state_r   <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (pop_s) begin
                            {calc_sel, calc_x, calc_y} <= head_s;
                            state_r <= EXEC;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
